// File: rtl/triumph_imem.sv
// Instruction memory with a streaming program loader; holds the core in reset
// until a program has been loaded, then serves registered instruction fetches.
module triumph_imem #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic        core_hold_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HI = AW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem [DEPTH];

  logic            xfer_c;
  logic            we_c;
  logic            at_end_c;
  logic            in_range_c;
  logic            rd_en_c;
  logic [AW-1:0]   ridx_c;

  assign xfer_c     = load_valid_i && (state_q == LOAD);
  assign we_c       = xfer_c && !rst_i;
  assign at_end_c   = (wcnt_q == AW'(DEPTH - 1));
  assign ridx_c     = instr_addr_i[HI-1:2];
  assign in_range_c = ~|instr_addr_i[31:HI];

  // Next-state, loader bookkeeping and fetch data selection
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rdata_d = NOP_INSTR;
    rd_en_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end
      end
      LOAD: begin
        if (xfer_c) begin
          if (!at_end_c) wcnt_d = wcnt_q + AW'(1);
          if (load_last_i) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else if (at_end_c) begin
            // Memory full without a last marker: flag overflow and release the core
            state_d = RUN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (load_start_i) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Fetch is live in RUN and in the cycle that enters RUN; same-word write forwards
    rd_en_c = (state_q == RUN) || (state_d == RUN);
    if (rd_en_c && in_range_c) begin
      if (we_c && (ridx_c == wcnt_q)) rdata_d = load_data_i;
      else                            rdata_d = mem[ridx_c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Program storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (we_c) mem[wcnt_q] <= load_data_i;
  end

  assign instr_rdata_o = rdata_q;
  assign load_ready_o  = (state_q == LOAD);
  assign load_done_o   = done_q;
  assign load_err_o    = err_q;
  assign core_hold_o   = (state_q != RUN);

endmodule

// File: tb/tb_triumph_imem.sv
// Directed-plus-random bench for triumph_imem against an array-based reference model.
module tb_triumph_imem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_addr, a_rdata, a_data;
  logic        a_start, a_valid, a_last, a_ready, a_done, a_err, a_hold;
  logic [31:0] b_addr, b_rdata, b_data;
  logic        b_start, b_valid, b_last, b_ready, b_done, b_err, b_hold;

  triumph_imem dut_a (
    .clk_i(clk), .rst_i(rst), .instr_addr_i(a_addr), .instr_rdata_o(a_rdata),
    .load_start_i(a_start), .load_valid_i(a_valid), .load_data_i(a_data),
    .load_last_i(a_last), .load_ready_o(a_ready), .load_done_o(a_done),
    .load_err_o(a_err), .core_hold_o(a_hold)
  );

  triumph_imem #(.DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .instr_addr_i(b_addr), .instr_rdata_o(b_rdata),
    .load_start_i(b_start), .load_valid_i(b_valid), .load_data_i(b_data),
    .load_last_i(b_last), .load_ready_o(b_ready), .load_done_o(b_done),
    .load_err_o(b_err), .core_hold_o(b_hold)
  );

  int          checks;
  int          passed;
  int          maxw;
  bit          a_run;
  logic [31:0] ref_mem [1024];
  logic [31:0] wbuf [64];
  logic [31:0] bw [5];
  logic [31:0] keep;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference fetch: word-addressed array, NOP when halted or beyond the 4 KiB window
  function automatic logic [31:0] exp_fetch(input logic [31:0] addr, input bit run);
    if (!run || addr >= 32'd4096) return NOP;
    return ref_mem[addr[11:2]];
  endfunction

  task automatic start_a;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_run   = 1'b0;
    check("start_ready", 32'(a_ready), 32'd1);
    check("start_hold", 32'(a_hold), 32'd1);
  endtask

  task automatic load_a(input int n, input int gmin, input int gmax);
    int g;
    a_addr = 32'((n - 1) * 4);
    for (int i = 0; i < n; i++) begin
      g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      for (int k = 0; k < g; k++) begin
        a_valid = 1'b0;
        a_data  = $urandom;
        tick;
        check("gap_ready", 32'(a_ready), 32'd1);
      end
      a_valid = 1'b1;
      a_data  = wbuf[i];
      a_last  = (i == n - 1);
      tick;
      ref_mem[i] = wbuf[i];
      if (i < n - 1) begin
        check("load_done_low", 32'(a_done), 32'd0);
        check("load_fetch_nop", a_rdata, NOP);
      end
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_run   = 1'b1;
    if (n > maxw) maxw = n;
    check("load_done", 32'(a_done), 32'd1);
    check("load_hold", 32'(a_hold), 32'd0);
    check("load_bypass", a_rdata, exp_fetch(a_addr, 1'b1));
    tick;
    check("done_pulse", 32'(a_done), 32'd0);
  endtask

  task automatic fetch_a(input string tag, input logic [31:0] addr);
    a_addr = addr;
    tick;
    check(tag, a_rdata, exp_fetch(addr, a_run));
  endtask

  initial begin
    checks = 0; passed = 0; maxw = 0; a_run = 1'b0;
    rst = 1'b1;
    a_addr = '0; a_data = '0; a_start = 0; a_valid = 0; a_last = 0;
    b_addr = '0; b_data = '0; b_start = 0; b_valid = 0; b_last = 0;
    tick;
    tick;
    check("rst_rdata", a_rdata, NOP);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_hold", 32'(a_hold), 32'd1);
    check("rst_b_hold", 32'(b_hold), 32'd1);
    rst = 1'b0;
    tick;
    check("idle_fetch", a_rdata, NOP);

    // Basic four-word load
    start_a;
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    load_a(4, 0, 0);
    a_addr = 32'h8;
    tick;
    check("fetch_0x8", a_rdata, 32'h33);
    fetch_a("fetch_oor", 32'h1000);
    check("fetch_oor_nop", a_rdata, NOP);
    fetch_a("fetch_lowbits", 32'h9);

    // Random program with random valid gaps, then random fetches
    start_a;
    begin
      int n;
      n = 12 + int'($urandom_range(8, 0));
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      load_a(n, 0, 2);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ad;
      if ($urandom_range(7, 0) == 0) ad = $urandom | 32'h1000;
      else ad = 32'($urandom_range(maxw - 1, 0) * 4) | 32'($urandom_range(3, 0));
      fetch_a("rand_fetch", ad);
    end

    // Two-word reload from RUN keeps word 5
    start_a;
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    load_a(2, 0, 0);
    fetch_a("reload_idx0", 32'h0);
    fetch_a("reload_idx5", 32'h14);

    // Three words with a one-cycle gap between each
    start_a;
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    load_a(3, 1, 1);
    fetch_a("gap_idx2", 32'h8);
    fetch_a("gap_idx3_kept", 32'hC);

    // Reset after two of four words
    start_a;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'b1;
      a_data  = $urandom;
      tick;
      ref_mem[i] = a_data;
    end
    a_data = 32'hDEAD_BEEF;
    rst    = 1'b1;
    tick;
    rst     = 1'b0;
    a_valid = 1'b0;
    a_run   = 1'b0;
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_err", 32'(a_err), 32'd0);
    check("abort_hold", 32'(a_hold), 32'd1);
    check("abort_ready", 32'(a_ready), 32'd0);
    check("abort_rdata", a_rdata, NOP);
    tick;
    check("abort_done_after", 32'(a_done), 32'd0);
    start_a;
    wbuf[0] = $urandom;
    load_a(1, 0, 0);
    fetch_a("abort_kept_idx1", 32'h4);
    fetch_a("abort_idx2_unwritten", 32'h8);

    // Overflow on the four-word instance
    for (int i = 0; i < 5; i++) bw[i] = $urandom;
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_5th_ready", 32'(b_ready), 32'd0);
      b_valid = 1'b1;
      b_data  = bw[i];
      tick;
      if (i < 3) begin
        check("ovf_err_low", 32'(b_err), 32'd0);
        check("ovf_ready", 32'(b_ready), 32'd1);
      end else if (i == 3) begin
        check("ovf_err", 32'(b_err), 32'd1);
        check("ovf_done", 32'(b_done), 32'd1);
        check("ovf_ready_low", 32'(b_ready), 32'd0);
        check("ovf_hold", 32'(b_hold), 32'd0);
      end else begin
        check("ovf_done_pulse", 32'(b_done), 32'd0);
        check("ovf_err_hold", 32'(b_err), 32'd1);
      end
    end
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_addr = 32'(i * 4);
      tick;
      check("ovf_word", b_rdata, bw[i]);
    end
    b_addr = 32'h10;
    tick;
    check("ovf_oor", b_rdata, NOP);
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    check("err_sticky_start", 32'(b_err), 32'd1);
    keep = $urandom;
    b_valid = 1'b1; b_last = 1'b1; b_data = keep;
    tick;
    b_valid = 1'b0; b_last = 1'b0;
    check("err_sticky_load", 32'(b_err), 32'd1);
    check("sticky_done", 32'(b_done), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("err_cleared", 32'(b_err), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/triumph_imem.md
TRIUMPH_IMEM -- requirements
Module: triumph_imem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the instruction word count (power of two, 2..65536).
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the word driven when no valid fetch data exists.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with all state updated on the rising edge of clk_i.
REQ-004 The block SHALL have port clk_i  input  1  clock.
REQ-005 The block SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port instr_addr_i  input  32  byte fetch address from the core.
REQ-007 The block SHALL have port instr_rdata_o  output  32  fetched instruction word.
REQ-008 The block SHALL have port load_start_i  input  1  single-cycle request to begin a program load.
REQ-009 The block SHALL have port load_valid_i  input  1  load word present.
REQ-010 The block SHALL have port load_data_i  input  32  load word.
REQ-011 The block SHALL have port load_last_i  input  1  current load word is the final word; qualified by load_valid_i.
REQ-012 The block SHALL have port load_ready_o  output  1  block accepts a load word this cycle.
REQ-013 The block SHALL have port load_done_o  output  1  one-cycle pulse at load completion.
REQ-014 The block SHALL have port load_err_o  output  1  sticky overflow flag.
REQ-015 The block SHALL have port core_hold_o  output  1  holds the core in reset while high.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD and RUN, with a word counter wcnt of width log2(DEPTH).
REQ-017 In IDLE, load_start_i=1 SHALL move to LOAD with wcnt=0; otherwise the FSM SHALL remain in IDLE.
REQ-018 In RUN, load_start_i=1 SHALL move to LOAD with wcnt=0, and core_hold_o SHALL be high from the next cycle.
REQ-019 In LOAD, load_start_i SHALL be ignored.
REQ-020 load_ready_o SHALL be 1 exactly when the state is LOAD (combinational from state).
REQ-021 A transfer (load_valid_i & load_ready_o) SHALL write load_data_i to mem[wcnt] and increment wcnt.
REQ-022 A transfer with load_last_i=1 SHALL move to RUN and pulse load_done_o=1 in the following cycle.
REQ-023 A transfer at wcnt=DEPTH-1 with load_last_i=0 SHALL write the word, set load_err_o, move to RUN and pulse load_done_o; wcnt SHALL not wrap before the exit.
REQ-024 load_err_o SHALL remain set until rst_i, and SHALL not be cleared by a new load_start_i.
REQ-025 core_hold_o SHALL be 1 in IDLE and LOAD and 0 in RUN.
REQ-026 Reads SHALL be registered with 1-cycle latency: instr_rdata_o at cycle n+1 SHALL equal mem[instr_addr_i[log2(DEPTH)+1:2]] for the address sampled at cycle n.
REQ-027 instr_addr_i[1:0] SHALL be ignored.
REQ-028 An address with any bit above log2(DEPTH)+1 set SHALL return NOP_INSTR.
REQ-029 A fetch sampled while the state is not RUN SHALL return NOP_INSTR.
REQ-030 A fetch sampled in the cycle the FSM enters RUN SHALL return memory data, so a write and a read of the same word in the same cycle SHALL return the new word on the next cycle.
REQ-031 Memory contents SHALL not be reset; words not written since power-up are undefined.

Reset
REQ-032 rst_i SHALL set state=IDLE, wcnt=0, instr_rdata_o=NOP_INSTR, load_ready_o=0, load_done_o=0, load_err_o=0 and core_hold_o=1.
REQ-033 rst_i asserted mid-load SHALL abort the load and retain words already written; the abort SHALL not pulse load_done_o.
REQ-034 rst_i SHALL take priority over every other input in the same cycle.

Verification
REQ-035 The bench SHALL cover basic load: start, then 4 words 0x11,0x22,0x33,0x44 with last on 0x44 -> load_done_o pulses 1 cycle, core_hold_o falls, fetching address 0x8 returns 0x33 one cycle later.
REQ-036 The bench SHALL cover backpressure-free gaps: load_valid_i toggling 1,0,1 over 3 words -> exactly 3 writes, wcnt=3 at exit.
REQ-037 The bench SHALL cover overflow: DEPTH=4 with 5 words offered and no last -> 4 written, load_err_o=1, RUN entered after word 4, and the 5th word not accepted (load_ready_o=0).
REQ-038 The bench SHALL cover out-of-range and held fetches: address 0x1000 with DEPTH=1024 returns 0x00000013, and any fetch in IDLE/LOAD returns 0x00000013.
REQ-039 The bench SHALL cover reload from RUN: load_start_i in RUN -> core_hold_o=1 next cycle, new words overwrite from index 0, and the old word at index 5 survives a 2-word reload.
REQ-040 The bench SHALL cover reset mid-load: rst_i after 2 of 4 words -> IDLE, load_done_o stays 0, load_err_o=0, core_hold_o=1.
